// File: rtl/cam_frame_writer.sv
// OV7670 byte bus -> RGB565 pixels cropped to a 256x256 window; write strobe lands one cycle after
// the second byte of a pixel is sampled. No backpressure: the buffer must accept one write every 2 clocks.
module cam_frame_writer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_OFF = 192,
  parameter int Y_OFF = 112
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        freeze,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic [9:0]  line_cnt,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    FRAME  = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t      state_q;
  logic        vs_q, hr_q, phase_q;
  logic [7:0]  hi_q;
  logic [9:0]  x_q, y_q;
  logic        wr_en_q, frame_done_q, err_q;
  logic [15:0] wr_addr_q, wr_data_q;
  logic [9:0]  line_cnt_q;

  logic        vs_rise, vs_fall, hr_fall, in_win;
  logic [9:0]  x_d, y_d;

  assign vs_rise = ~vs_q & cam_vsync;
  assign vs_fall = vs_q & ~cam_vsync;
  assign hr_fall = hr_q & ~cam_href;

  // y_d already includes a line closed on this sample, so a same-cycle vsync rise counts it.
  assign x_d = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
  assign y_d = !hr_fall ? y_q : ((y_q == 10'h3FF) ? y_q : y_q + 10'd1);

  assign in_win = (int'(x_q) >= X_OFF) && (int'(x_q) < X_OFF + 256) && (int'(x_q) < IMG_W)
               && (int'(y_q) >= Y_OFF) && (int'(y_q) < Y_OFF + 256);

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      vs_q         <= 1'b0;
      hr_q         <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= 8'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 16'd0;
      frame_done_q <= 1'b0;
      line_cnt_q   <= 10'd0;
      err_q        <= 1'b0;
    end else begin
      vs_q         <= cam_vsync;
      hr_q         <= cam_href;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        WAIT: begin
          if (vs_fall) begin
            state_q <= FRAME;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            phase_q <= 1'b0;
          end
        end
        FRAME: begin
          if (hr_fall) begin
            y_q     <= y_d;
            x_q     <= 10'd0;
            phase_q <= 1'b0;
            if (phase_q) err_q <= 1'b1;
          end else if (cam_href && !vs_rise) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_q <= cam_data;
            end else begin
              x_q <= x_d;
              if (in_win) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= {8'(y_q - 10'(Y_OFF)), 8'(x_q - 10'(X_OFF))};
                wr_data_q <= {hi_q, cam_data};
              end
            end
          end
          if (vs_rise) begin
            frame_done_q <= 1'b1;
            line_cnt_q   <= y_d;
            if (y_d != 10'(IMG_H)) err_q <= 1'b1;
            state_q      <= freeze ? FROZEN : WAIT;
          end
        end
        FROZEN: begin
          if (!freeze) state_q <= WAIT;
        end
        default: state_q <= WAIT;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign line_cnt   = line_cnt_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed frame sequences with random pixel bytes; expected writes come from a line/pixel-level model.
`timescale 1ns/1ps
module tb_cam_frame_writer;
  localparam int IMG_W = 24;
  localparam int IMG_H = 12;
  localparam int X_OFF = 5;
  localparam int Y_OFF = 3;

  logic        cam_pclk = 1'b0;
  logic        rst_n, cam_vsync, cam_href, freeze;
  logic [7:0]  cam_data;
  logic        wr_en, frame_done, err;
  logic [15:0] wr_addr, wr_data;
  logic [9:0]  line_cnt;
  logic [1:0]  state_dbg;

  cam_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF)) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .freeze(freeze), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .line_cnt(line_cnt), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 cam_pclk = ~cam_pclk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          fd_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  // Model state: capturing, frozen, sticky error, current line, last line count, frame_done count.
  bit m_cap = 1'b0, m_frozen = 1'b0, m_err = 1'b0;
  int m_line = 0, m_lcnt = 0, m_fd = 0;

  always @(posedge cam_pclk) cyc <= cyc + 1;

  always @(negedge cam_pclk) begin
    if (wr_en === 1'b1) obs_q.push_back({cyc, wr_addr, wr_data});
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= X_OFF) && (x < X_OFF + 256) && (y >= Y_OFF) && (y < Y_OFF + 256);
  endfunction

  task automatic close_model(input int nbytes);
    if (m_cap) begin
      m_line++;
      if (nbytes % 2 != 0) m_err = 1'b1;
    end
  endtask

  task automatic send_line(input int nbytes, input bit close);
    logic [7:0] b;
    logic [7:0] hi;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = b;
      if (i % 2 == 0) hi = b;
      else if (m_cap && in_win(i / 2, m_line))
        exp_q.push_back({cyc + 32'd1, 8'(m_line - Y_OFF), 8'(i / 2 - X_OFF), hi, b});
    end
    if (close) begin
      @(negedge cam_pclk);
      cam_href = 1'b0;
      close_model(nbytes);
      @(negedge cam_pclk);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic start_frame();
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (2) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    if (!m_frozen) begin
      m_cap  = 1'b1;
      m_line = 0;
    end
    @(negedge cam_pclk);
    check("state_after_vs_fall", state_dbg, m_frozen ? 2 : 1);
  endtask

  task automatic end_frame(input string tag, input bit close, input bit with_byte);
    bit was_cap;
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    if (close) begin
      cam_href = 1'b0;
      close_model(0);
    end
    if (with_byte) begin
      cam_href = 1'b1;
      cam_data = 8'($urandom);
    end
    was_cap = m_cap;
    if (m_cap) begin
      m_fd++;
      m_lcnt = m_line;
      if (m_line != IMG_H) m_err = 1'b1;
      m_cap    = 1'b0;
      m_frozen = freeze;
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    check({tag, "_frame_done"}, frame_done, was_cap);
    check({tag, "_line_cnt"}, line_cnt, m_lcnt);
    check({tag, "_err"}, err, m_err);
    check({tag, "_state"}, state_dbg, m_frozen ? 2 : 0);
    @(negedge cam_pclk);
    check({tag, "_frame_done_width"}, frame_done, 0);
    check({tag, "_frame_done_count"}, fd_cnt, m_fd);
    compare_writes(tag);
  endtask

  task automatic full_frame(input string tag);
    start_frame();
    for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W, 1'b1);
    end_frame(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0; freeze = 1'b0;
    repeat (3) @(negedge cam_pclk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;

    // vsync never seen high: lines must not be captured.
    for (int l = 0; l < 3; l++) send_line(2 * IMG_W, 1'b1);
    check("guard_state", state_dbg, 0);
    compare_writes("startup_guard");

    full_frame("frame1");

    // Freeze raised mid-frame: this frame completes, the next is ignored.
    start_frame();
    for (int l = 0; l < IMG_H; l++) begin
      if (l == IMG_H / 2) freeze = 1'b1;
      send_line(2 * IMG_W, 1'b1);
    end
    end_frame("freeze_frame", 1'b0, 1'b0);
    full_frame("frozen_frame");
    @(negedge cam_pclk);
    freeze = 1'b0;
    @(negedge cam_pclk);
    check("unfreeze_state", state_dbg, 0);
    m_frozen = 1'b0;
    full_frame("after_unfreeze");

    // Async reset mid-line.
    start_frame();
    for (int l = 0; l < 5; l++) send_line(2 * IMG_W, 1'b1);
    send_line(7, 1'b0);
    @(posedge cam_pclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_line_cnt", line_cnt, 0);
    check("arst_err", err, 0);
    check("arst_state", state_dbg, 0);
    compare_writes("pre_reset");
    m_cap = 1'b0; m_err = 1'b0; m_lcnt = 0; m_frozen = 1'b0;
    repeat (2) @(negedge cam_pclk);
    rst_n = 1'b1;
    send_line(2 * IMG_W - 7, 1'b1);
    for (int l = 0; l < 3; l++) send_line(2 * IMG_W, 1'b1);
    check("post_reset_state", state_dbg, 0);
    compare_writes("post_reset_guard");

    // Short frame: vsync rises mid-href on the byte that would complete a pixel.
    start_frame();
    for (int l = 0; l < 7; l++) send_line(2 * IMG_W, 1'b1);
    send_line(17, 1'b0);
    end_frame("short_frame", 1'b0, 1'b1);

    @(negedge cam_pclk);
    rst_n = 1'b0;
    @(negedge cam_pclk);
    check("reset_clears_err", err, 0);
    check("reset_clears_line_cnt", line_cnt, 0);
    rst_n = 1'b1;
    m_cap = 1'b0; m_err = 1'b0; m_lcnt = 0;

    // Odd line, and the last line closes on the same sample as the vsync rise.
    start_frame();
    for (int l = 0; l < IMG_H - 1; l++) send_line((l == 4) ? 2 * IMG_W - 1 : 2 * IMG_W, 1'b1);
    send_line(2 * IMG_W, 1'b0);
    end_frame("odd_line_frame", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
